dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
// - Sequences data-memory accesses for the MEM stage of the 5-stage RV32I pipeline.
// - Converts MEM-stage load/store control (MemWriteM, ResultSrcM, AluoutM, Mem_dataM)
//   into a req/gnt/ack handshake to a multi-cycle data memory.
// - Stalls the pipeline until the access completes or times out.
// - Holds load data for the MEM/WB register.
// PARAMETERS
// - ADDR_W     32  address width (byte address from AluoutM)
// - DATA_W     32  data width (word accesses only)
// - TIMEOUT    16  max cycles in REQ+WAIT before abort; must be >= 2
// - CNT_W       5  timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
// - clk         in   1       clock; all state updates on rising edge
// - rst         in   1       asynchronous reset, active-low (0 = reset)
// - validM      in   1       MEM stage holds a real instruction (not a bubble)
// - MemWriteM   in   1       store in MEM stage
// - ResultSrcM  in   1       load in MEM stage (result taken from memory)
// - AluoutM     in   ADDR_W  byte address
// - Mem_dataM   in   DATA_W  store data
// - mem_req     out  1       request to memory, registered
// - mem_we      out  1       1 = write, registered
// - mem_addr    out  ADDR_W  registered word address {AluoutM[ADDR_W-1:2],2'b00}
// - mem_wdata   out  DATA_W  registered store data
// - mem_gnt     in   1       memory accepted request; sampled only while mem_req=1
// - mem_ack     in   1       access complete; sampled in REQ (after gnt) or WAIT
// - mem_rdata   in   DATA_W  read data; valid when mem_ack=1
// - stallM      out  1       freeze F/D/E/M pipeline registers (combinational)
// - ReadDataM   out  DATA_W  captured load data; held until the next load completes
// - done        out  1       1-cycle pulse: access retired
// - bus_err     out  1       1-cycle pulse with done: timeout
// - misalign    out  1       1-cycle pulse: AluoutM[1:0]!=0; no request is issued
// BEHAVIOUR
// - acc = validM & (MemWriteM | ResultSrcM). If both MemWriteM and ResultSrcM are set,
//   the access is a store.
// - Reset (rst=0, async): state=IDLE, cnt=0. All registered outputs are 0.
//   ReadDataM=0. An in-flight access is abandoned; the memory must tolerate a dropped req.
// - FSM states: IDLE, REQ, WAIT, DONE.
// - IDLE:
//   - acc & aligned: latch mem_addr/mem_we/mem_wdata, go to REQ.
//   - acc & misaligned: pulse misalign, stay in IDLE, issue no request.
//   - stallM=0 on misalign. The trap is handled elsewhere.
// - REQ: mem_req=1, cnt++.
//   - gnt&ack: go to DONE.
//   - gnt&!ack: go to WAIT.
//   - else: stay in REQ.
// - WAIT: mem_req=0, cnt++. ack: go to DONE.
// - Read-data capture: on each ack in REQ or WAIT where mem_we=0, ReadDataM<=mem_rdata.
// - Timeout: cnt==TIMEOUT-1 in REQ or WAIT with no ack -> go to DONE, set bus_err,
//   set ReadDataM=0 for a load, drop mem_req.
// - Ack vs timeout: ack in the same cycle as the timeout wins; bus_err stays 0.
// - DONE: done=1, stallM=0 (the pipeline advances exactly once), cnt=0, go to IDLE.
//   The next MEM instruction can start at the earliest in the following IDLE cycle.
// - stallM = (IDLE & acc & aligned) | REQ | WAIT. Never asserted in DONE.
// - Stalled-input rule: AluoutM and Mem_dataM are only sampled on IDLE->REQ. Input
//   changes during REQ/WAIT are ignored.
// - Latency: a zero-wait memory (gnt&ack in the first REQ cycle) costs 2 stall cycles.
//   Each wait cycle adds 1.
// - Counter: saturating, never wraps. Width CNT_W.
// STRUCTURE
// - Shared package dmem_pkg:
//   - state encoding localparams (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3)
//   - default TIMEOUT
// - No sub-module. Single FSM with a counter.
// - EX_MEM and MEM_WB registers consume stallM as an enable.
// TESTING
// - Store, zero-wait: addr=0x100, data=0xDEADBEEF, gnt&ack in 1st REQ cycle
//   -> mem_we=1, stallM=1 for 2 cycles, done pulse.
// - Load, 3 wait cycles: addr=0x200, ack 3 cycles after gnt, rdata=0x12345678
//   -> ReadDataM=0x12345678, stallM=1 for 5 cycles.
// - Misaligned load: addr=0x103 -> misalign pulse, mem_req never asserted, stallM=0.
// - Timeout: TIMEOUT=16, no gnt -> after 16 REQ cycles bus_err=1 with done,
//   ReadDataM=0, mem_req=0.
// - Reset mid-WAIT: drop rst for 1 cycle -> state IDLE, all outputs 0 immediately (async).
// - Back-to-back: store then load in consecutive MEM slots -> exactly one done per access,
//   second req starts one cycle after DONE.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the MEM-stage
// data-memory access controller.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } state_t;

  function automatic logic is_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: req/gnt/ack bus between the MEM-stage
// controller (master) and the multi-cycle data memory (slave).
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_gnt,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_gnt,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a
// req/gnt/ack data memory, stalling the pipeline until retire.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [ADDR_W-1:0] AluoutM,
  input  logic [DATA_W-1:0] Mem_dataM,
  dmem_access_ctrl_if.master mem,
  output logic              stallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              done,
  output logic              bus_err,
  output logic              misalign
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic             acc;
  logic             aligned;
  logic             tmo;
  logic             fin_ok;
  logic             fin_tmo;
  logic [CNT_W-1:0] cnt_inc;

  assign acc     = validM & (MemWriteM | ResultSrcM);
  assign aligned = is_aligned(AluoutM[1:0]);
  assign tmo     = cnt_q == CNT_W'(TIMEOUT - 1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q
                                 : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    fin_ok  = 1'b0;
    fin_tmo = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc && aligned) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {AluoutM[ADDR_W-1:2], 2'b00};
          wdata_d = Mem_dataM;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (mem.mem_gnt && mem.mem_ack) begin
          fin_ok = 1'b1;
        end else if (tmo) begin
          fin_tmo = 1'b1;
        end else if (mem.mem_gnt) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (mem.mem_ack) begin
          fin_ok = 1'b1;
        end else if (tmo) begin
          fin_tmo = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // An ack in the timeout cycle retires normally
    if (fin_ok || fin_tmo) begin
      state_d = DONE;
      req_d   = 1'b0;
      err_d   = fin_tmo;
      if (!we_q) begin
        rdata_d = fin_ok ? mem.mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // Gated by rst so the pipeline is never frozen while held in reset
  assign stallM = rst & (((state_q == IDLE) & acc & aligned)
                       | (state_q == REQ)
                       | (state_q == WAIT));
  assign misalign  = rst & (state_q == IDLE) & acc & ~aligned;
  assign done      = (state_q == DONE);
  assign bus_err   = (state_q == DONE) & err_q;
  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: vector table plus directed sequences
// for timeout, ack/timeout tie and asynchronous reset.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        validM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [31:0] AluoutM;
  logic [31:0] Mem_dataM;
  logic        stallM;
  logic [31:0] ReadDataM;
  logic        done;
  logic        bus_err;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16),
    .CNT_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .validM    (validM),
    .MemWriteM (MemWriteM),
    .ResultSrcM(ResultSrcM),
    .AluoutM   (AluoutM),
    .Mem_dataM (Mem_dataM),
    .mem       (bus),
    .stallM    (stallM),
    .ReadDataM (ReadDataM),
    .done      (done),
    .bus_err   (bus_err),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, w, r;
    logic [31:0] a, d;
    logic        g, k;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_stall, e_done, e_err, e_mis;
    logic [31:0] e_rdm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic v, w, r,
    input logic [31:0] a, d,
    input logic g, k,
    input logic [31:0] rd,
    input logic er, ew,
    input logic [31:0] ea, ed,
    input logic es, edn, eer, emi,
    input logic [31:0] erd
  );
    vec_t t;
    t.v = v; t.w = w; t.r = r;
    t.a = a; t.d = d;
    t.g = g; t.k = k; t.rd = rd;
    t.e_req = er; t.e_we = ew;
    t.e_addr = ea; t.e_wd = ed;
    t.e_stall = es; t.e_done = edn;
    t.e_err = eer; t.e_mis = emi;
    t.e_rdm = erd;
    return t;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(
    input logic v, w, r,
    input logic [31:0] a, d,
    input logic g, k,
    input logic [31:0] rd
  );
    validM        = v;
    MemWriteM     = w;
    ResultSrcM    = r;
    AluoutM       = a;
    Mem_dataM     = d;
    bus.mem_gnt   = g;
    bus.mem_ack   = k;
    bus.mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req",   bus.mem_req,   0);
    chk("rst.we",    bus.mem_we,    0);
    chk("rst.addr",  bus.mem_addr,  0);
    chk("rst.wdata", bus.mem_wdata, 0);
    chk("rst.stall", stallM,        0);
    chk("rst.done",  done,          0);
    chk("rst.err",   bus_err,       0);
    chk("rst.rdm",   ReadDataM,     0);
    rst = 1'b1;
    step();

    // store zero-wait @0x100
    tv.push_back(mk(1,1,0,32'h100,32'hDEADBEEF,0,0,0, 0,0,0,0, 1,0,0,0, 0));
    tv.push_back(mk(1,1,0,32'h100,32'hDEADBEEF,1,1,0,
                    1,1,32'h100,32'hDEADBEEF, 1,0,0,0, 0));
    tv.push_back(mk(1,1,0,32'h100,32'hDEADBEEF,0,0,0,
                    0,1,32'h100,32'hDEADBEEF, 0,1,0,0, 0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,
                    0,1,32'h100,32'hDEADBEEF, 0,0,0,0, 0));
    // load @0x200, ack 3 cycles after gnt, inputs change mid-wait
    tv.push_back(mk(1,0,1,32'h200,0,0,0,0,
                    0,1,32'h100,32'hDEADBEEF, 1,0,0,0, 0));
    tv.push_back(mk(1,0,1,32'h200,0,1,0,0, 1,0,32'h200,0, 1,0,0,0, 0));
    tv.push_back(mk(1,0,1,32'h300,32'hFFFFFFFF,0,0,0,
                    0,0,32'h200,0, 1,0,0,0, 0));
    tv.push_back(mk(1,0,1,32'h300,32'hFFFFFFFF,0,0,0,
                    0,0,32'h200,0, 1,0,0,0, 0));
    tv.push_back(mk(1,0,1,32'h300,32'hFFFFFFFF,0,1,32'h12345678,
                    0,0,32'h200,0, 1,0,0,0, 0));
    tv.push_back(mk(1,0,1,32'h300,32'hFFFFFFFF,0,0,0,
                    0,0,32'h200,0, 0,1,0,0, 32'h12345678));
    // misaligned load
    tv.push_back(mk(1,0,1,32'h103,0,0,0,0,
                    0,0,32'h200,0, 0,0,0,1, 32'h12345678));
    tv.push_back(mk(0,0,0,0,0,0,0,0,
                    0,0,32'h200,0, 0,0,0,0, 32'h12345678));
    // back-to-back store then load
    tv.push_back(mk(1,1,0,32'h40,32'h11112222,0,0,0,
                    0,0,32'h200,0, 1,0,0,0, 32'h12345678));
    tv.push_back(mk(1,1,0,32'h40,32'h11112222,1,1,0,
                    1,1,32'h40,32'h11112222, 1,0,0,0, 32'h12345678));
    tv.push_back(mk(1,1,0,32'h40,32'h11112222,0,0,0,
                    0,1,32'h40,32'h11112222, 0,1,0,0, 32'h12345678));
    tv.push_back(mk(1,0,1,32'h44,0,0,0,0,
                    0,1,32'h40,32'h11112222, 1,0,0,0, 32'h12345678));
    tv.push_back(mk(1,0,1,32'h44,0,1,1,32'hCAFEF00D,
                    1,0,32'h44,0, 1,0,0,0, 32'h12345678));
    tv.push_back(mk(1,0,1,32'h44,0,0,0,0,
                    0,0,32'h44,0, 0,1,0,0, 32'hCAFEF00D));
    tv.push_back(mk(0,0,0,0,0,0,0,0,
                    0,0,32'h44,0, 0,0,0,0, 32'hCAFEF00D));
    // both MemWrite and ResultSrc: treated as store
    tv.push_back(mk(1,1,1,32'h80,32'h55,0,0,0,
                    0,0,32'h44,0, 1,0,0,0, 32'hCAFEF00D));
    tv.push_back(mk(1,1,1,32'h80,32'h55,1,1,32'h99,
                    1,1,32'h80,32'h55, 1,0,0,0, 32'hCAFEF00D));
    tv.push_back(mk(1,1,1,32'h80,32'h55,0,0,0,
                    0,1,32'h80,32'h55, 0,1,0,0, 32'hCAFEF00D));
    // bubble carrying MemWrite is ignored
    tv.push_back(mk(0,1,0,32'h100,0,0,0,0,
                    0,1,32'h80,32'h55, 0,0,0,0, 32'hCAFEF00D));
    // load @0x8: ack without gnt ignored, then gnt&ack
    tv.push_back(mk(1,0,1,32'h8,0,0,0,0,
                    0,1,32'h80,32'h55, 1,0,0,0, 32'hCAFEF00D));
    tv.push_back(mk(1,0,1,32'h8,0,0,1,32'hBAD,
                    1,0,32'h8,0, 1,0,0,0, 32'hCAFEF00D));
    tv.push_back(mk(1,0,1,32'h8,0,1,1,32'hAB12,
                    1,0,32'h8,0, 1,0,0,0, 32'hCAFEF00D));
    tv.push_back(mk(1,0,1,32'h8,0,0,0,0,
                    0,0,32'h8,0, 0,1,0,0, 32'hAB12));
    tv.push_back(mk(0,0,0,0,0,0,0,0,
                    0,0,32'h8,0, 0,0,0,0, 32'hAB12));

    for (int i = 0; i < tv.size(); i++) begin
      drv(tv[i].v, tv[i].w, tv[i].r, tv[i].a, tv[i].d,
          tv[i].g, tv[i].k, tv[i].rd);
      @(negedge clk);
      chk($sformatf("r%0d.req", i),   bus.mem_req,   tv[i].e_req);
      chk($sformatf("r%0d.we", i),    bus.mem_we,    tv[i].e_we);
      chk($sformatf("r%0d.addr", i),  bus.mem_addr,  tv[i].e_addr);
      chk($sformatf("r%0d.wdata", i), bus.mem_wdata, tv[i].e_wd);
      chk($sformatf("r%0d.stall", i), stallM,        tv[i].e_stall);
      chk($sformatf("r%0d.done", i),  done,          tv[i].e_done);
      chk($sformatf("r%0d.err", i),   bus_err,       tv[i].e_err);
      chk($sformatf("r%0d.mis", i),   misalign,      tv[i].e_mis);
      chk($sformatf("r%0d.rdm", i),   ReadDataM,     tv[i].e_rdm);
      step();
    end

    // timeout: load, never granted
    drv(1, 0, 1, 32'h300, 0, 0, 0, 0);
    @(negedge clk);
    chk("to.idle.stall", stallM, 1);
    step();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("to.c%0d.req", i),   bus.mem_req, 1);
      chk($sformatf("to.c%0d.stall", i), stallM,      1);
      chk($sformatf("to.c%0d.done", i),  done,        0);
      step();
    end
    @(negedge clk);
    chk("to.done",  done,        1);
    chk("to.err",   bus_err,     1);
    chk("to.req",   bus.mem_req, 0);
    chk("to.rdm",   ReadDataM,   0);
    chk("to.stall", stallM,      0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("to.after.done", done,    0);
    chk("to.after.err",  bus_err, 0);
    step();

    // ack in the timeout cycle wins
    drv(1, 0, 1, 32'h304, 0, 0, 0, 0);
    step();
    drv(1, 0, 1, 32'h304, 0, 1, 0, 0);
    @(negedge clk);
    chk("tie.req", bus.mem_req, 1);
    step();
    drv(1, 0, 1, 32'h304, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("tie.w%0d.stall", i), stallM, 1);
      chk($sformatf("tie.w%0d.done", i),  done,   0);
      step();
    end
    drv(1, 0, 1, 32'h304, 0, 0, 1, 32'h0BADCAFE);
    @(negedge clk);
    chk("tie.last.stall", stallM, 1);
    step();
    drv(1, 0, 1, 32'h304, 0, 0, 0, 0);
    @(negedge clk);
    chk("tie.done", done,      1);
    chk("tie.err",  bus_err,   0);
    chk("tie.rdm",  ReadDataM, 32'h0BADCAFE);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // async reset while in WAIT
    drv(1, 1, 0, 32'h500, 32'h77, 0, 0, 0);
    step();
    drv(1, 1, 0, 32'h500, 32'h77, 1, 0, 0);
    step();
    drv(1, 1, 0, 32'h500, 32'h77, 0, 0, 0);
    @(negedge clk);
    chk("ar.wait.stall", stallM, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar.req",   bus.mem_req,   0);
    chk("ar.we",    bus.mem_we,    0);
    chk("ar.addr",  bus.mem_addr,  0);
    chk("ar.wdata", bus.mem_wdata, 0);
    chk("ar.stall", stallM,        0);
    chk("ar.done",  done,          0);
    chk("ar.mis",   misalign,      0);
    chk("ar.rdm",   ReadDataM,     0);
    @(negedge clk);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drv(1, 1, 0, 32'h600, 32'h66, 0, 0, 0);
    @(negedge clk);
    chk("ar.post.stall", stallM, 1);
    step();
    drv(1, 1, 0, 32'h600, 32'h66, 1, 1, 0);
    @(negedge clk);
    chk("ar.post.req",  bus.mem_req,  1);
    chk("ar.post.addr", bus.mem_addr, 32'h600);
    step();
    drv(1, 1, 0, 32'h600, 32'h66, 0, 0, 0);
    @(negedge clk);
    chk("ar.post.done", done,    1);
    chk("ar.post.err",  bus_err, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
